fpu_div_sched: RTL

Round-robin scheduler that shares one single-precision FPU divide datapath among `N_REQ` requesters. It accepts one divide at a time, holds the operands stable on the datapath for a programmable settle latency, and captures the quotient. It then returns the quotient to the originating requester over a valid/ready handshake. It sits between the FPU issue ports and the divide datapath, whose inputs `div_a`/`div_b` it drives and whose `div_result` it samples.

---
 rtl/fpu_div_sched.sv | 113 +++++++++++
 1 files changed

// File: rtl/fpu_div_sched.sv
// Round-robin scheduler sharing one FPU divide datapath among N_REQ requesters.
// Define FPU_DIV_SCHED_ZERO_BYPASS_EN to send zero-divisor requests straight to RESP.
module fpu_div_sched #(
    parameter int N_REQ   = 4,
    parameter int DIV_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_dz,
    output logic [31:0]          div_a,
    output logic [31:0]          div_b,
    input  logic [31:0]          div_result,
    output logic                 busy
);
    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   ptr, tag, gnt_idx, ptr_nxt;
    logic            gnt_any, gnt_zero, accept, bypass;
    logic [31:0]     gnt_a, gnt_b, res;
    logic [3:0]      cnt;
    logic            dz;
    int              idx;

    // Scan downward so the lowest offset from ptr is the last (winning) write.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = TW'(idx);
            end
        end
    end

    assign gnt_a    = req_a[32*int'(gnt_idx) +: 32];
    assign gnt_b    = req_b[32*int'(gnt_idx) +: 32];
    assign gnt_zero = (gnt_b == 32'h0);
    assign accept   = (state == IDLE) && gnt_any;
    assign ptr_nxt  = (tag == TW'(N_REQ - 1)) ? '0 : tag + TW'(1);

`ifdef FPU_DIV_SCHED_ZERO_BYPASS_EN
    assign bypass = gnt_zero;
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = bypass ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
            RESP: if (rsp_ready[tag]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept)         req_ready[gnt_idx] = 1'b1;
        if (state == RESP)  rsp_valid[tag]     = 1'b1;
    end

    assign busy       = (state != IDLE);
    assign rsp_result = res;
    assign rsp_dz     = dz;

    // Operands are only loaded on accept so the datapath sees stable inputs for the whole WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            tag   <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
            res   <= '0;
            div_a <= '0;
            div_b <= '0;
        end else if (accept) begin
            tag <= gnt_idx;
            dz  <= gnt_zero;
            if (bypass) begin
                res <= '0;
            end else begin
                div_a <= gnt_a;
                div_b <= gnt_b;
                cnt   <= 4'(DIV_LAT - 1);
            end
        end else if (state == WAIT) begin
            if (cnt == 4'd0) res <= dz ? 32'h0 : div_result;
            else             cnt <= cnt - 4'd1;
        end else if (state == RESP && rsp_ready[tag]) begin
            ptr <= ptr_nxt;
        end
    end
endmodule
